// File: rtl/snn_seq_pkg.sv
// rtl/snn_seq_pkg.sv - shared state encoding, default sizes and popcount for the SNN run sequencer
package snn_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_IN = 3'd1,
        ST_EVAL    = 3'd2,
        ST_DCLK    = 3'd3,
        ST_SETTLE  = 3'd4,
        ST_SAMPLE  = 3'd5,
        ST_DONE    = 3'd6
    } seq_state_e;

    localparam int DEF_M1            = 16;
    localparam int DEF_N1            = 8;
    localparam int DEF_N2            = 2;
    localparam int DEF_CNT_W         = 8;
    localparam int DEF_ACT_W         = 12;
    localparam int DEF_EVAL_CYCLES   = 1;
    localparam int DEF_SETTLE_CYCLES = 2;

    // Step counters, num_steps and the phase timer share this width.
    localparam int STEP_W = 8;
    localparam int POP_W  = 6;

    // Number of set bits in a vector of up to 32 layer-1 spikes.
    function automatic logic [POP_W-1:0] popcount32(input logic [31:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {{(POP_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/snn_sat_accumulator.sv
// rtl/snn_sat_accumulator.sv - saturating accumulator register with synchronous clear
module snn_sat_accumulator #(
    parameter int W     = 8,
    parameter int INC_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             add_en_i,
    input  logic [INC_W-1:0] inc_i,
    output logic [W-1:0]     acc_o
);

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;
    logic [W:0]   sum;

    // Clear wins over add; the extra sum bit flags overflow and pins the result at all-ones.
    always_comb begin
        sum   = {1'b0, acc_q} + (W+1)'(inc_i);
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (add_en_i) begin
            acc_d = sum[W] ? {W{1'b1}} : sum[W-1:0];
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/snn_timestep_sequencer.sv
// rtl/snn_timestep_sequencer.sv - timestep run controller for the two-layer delay SNN
module snn_timestep_sequencer
    import snn_seq_pkg::*;
#(
    parameter int M1            = DEF_M1,
    parameter int N1            = DEF_N1,
    parameter int N2            = DEF_N2,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int ACT_W         = DEF_ACT_W,
    parameter int EVAL_CYCLES   = DEF_EVAL_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int WIN_W         = (N2 > 1) ? $clog2(N2) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [7:0]          num_steps,
    input  logic                in_valid,
    input  logic [M1-1:0]       in_spikes,
    output logic                in_ready,
    output logic                net_enable,
    output logic                net_delay_clk,
    output logic [M1-1:0]       net_input_spikes,
    input  logic [N1-1:0]       net_spikes_l1,
    input  logic [N2-1:0]       net_spikes_out,
    output logic                busy,
    output logic                done,
    output logic [N2*CNT_W-1:0] spike_counts,
    output logic [ACT_W-1:0]    l1_activity,
    output logic [WIN_W-1:0]    winner,
    output logic [7:0]          step_idx
);

    seq_state_e        state_q, state_d;
    logic [STEP_W-1:0] num_q, step_q, phase_q;
    logic [STEP_W-1:0] step_inc;
    logic [M1-1:0]     net_in_q;
    logic              in_ready_q, net_enable_q, net_dclk_q, busy_q, done_q;
    logic [WIN_W-1:0]  winner_q, win_d;
    logic [CNT_W-1:0]  cnt_q    [N2];
    logic [CNT_W-1:0]  cnt_next [N2];
    logic [CNT_W-1:0]  best;
    logic [ACT_W-1:0]  act_q;
    logic [POP_W-1:0]  l1_inc;
    logic              start_go, sample_en, last_step;

    assign start_go  = (state_q == ST_IDLE) && start && !abort;
    assign sample_en = (state_q == ST_SAMPLE) && !abort;
    assign step_inc  = step_q + STEP_W'(1);
    assign last_step = (step_inc == num_q);
    assign l1_inc    = popcount32(32'(net_spikes_l1));

    // One saturating counter per output neuron; a run start clears them.
    for (genvar k = 0; k < N2; k++) begin : g_cnt
        snn_sat_accumulator #(.W(CNT_W), .INC_W(1)) u_cnt (
            .clk      (clk),
            .reset    (reset),
            .clr_i    (start_go),
            .add_en_i (sample_en),
            .inc_i    (net_spikes_out[k]),
            .acc_o    (cnt_q[k])
        );
    end

    snn_sat_accumulator #(.W(ACT_W), .INC_W(POP_W)) u_act (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (start_go),
        .add_en_i (sample_en),
        .inc_i    (l1_inc),
        .acc_o    (act_q)
    );

    // Counts as they will be after the final sample, so the winner is ready with done.
    always_comb begin
        win_d = '0;
        for (int k = 0; k < N2; k++) begin
            cnt_next[k] = cnt_q[k];
            if (net_spikes_out[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
                cnt_next[k] = cnt_q[k] + CNT_W'(1);
            end
        end
        best = cnt_next[0];
        for (int k = 1; k < N2; k++) begin
            if (cnt_next[k] > best) begin
                best  = cnt_next[k];
                win_d = WIN_W'(k);
            end
        end
    end

    // Next-state selection; abort overrides every transition including the handshake.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    if (start) state_d = (num_steps == 8'd0) ? ST_DONE : ST_WAIT_IN;
                ST_WAIT_IN: if (in_valid) state_d = ST_EVAL;
                ST_EVAL:    if (phase_q == '0) state_d = ST_DCLK;
                ST_DCLK:    state_d = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
                ST_SETTLE:  if (phase_q == '0) state_d = ST_SAMPLE;
                ST_SAMPLE:  state_d = last_step ? ST_DONE : ST_WAIT_IN;
                ST_DONE:    state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // State, phase timer, run bookkeeping and Moore outputs registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            num_q        <= '0;
            step_q       <= '0;
            net_in_q     <= '0;
            winner_q     <= '0;
            in_ready_q   <= 1'b0;
            net_enable_q <= 1'b0;
            net_dclk_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= (state_d == ST_WAIT_IN);
            net_enable_q <= (state_d == ST_EVAL);
            net_dclk_q   <= (state_d == ST_DCLK);
            busy_q       <= (state_d != ST_IDLE) && (state_d != ST_DONE);
            done_q       <= (state_d == ST_DONE);

            if ((state_d == ST_EVAL) && (state_q != ST_EVAL)) begin
                phase_q <= STEP_W'(EVAL_CYCLES - 1);
            end else if ((state_d == ST_SETTLE) && (state_q != ST_SETTLE)) begin
                phase_q <= STEP_W'(SETTLE_CYCLES - 1);
            end else if (phase_q != '0) begin
                phase_q <= phase_q - STEP_W'(1);
            end

            if (start_go) begin
                num_q    <= num_steps;
                step_q   <= '0;
                net_in_q <= '0;
                winner_q <= '0;
            end else begin
                if ((state_q == ST_WAIT_IN) && in_valid && !abort) begin
                    net_in_q <= in_spikes;
                end
                if (sample_en) begin
                    step_q <= step_inc;
                    if (last_step) begin
                        winner_q <= win_d;
                    end
                end
            end
        end
    end

    // Pack per-neuron counters into the flat result bus.
    always_comb begin
        spike_counts = '0;
        for (int k = 0; k < N2; k++) begin
            spike_counts[k*CNT_W +: CNT_W] = cnt_q[k];
        end
    end

    assign in_ready         = in_ready_q;
    assign net_enable       = net_enable_q;
    assign net_delay_clk    = net_dclk_q;
    assign net_input_spikes = net_in_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign l1_activity      = act_q;
    assign winner           = winner_q;
    assign step_idx         = step_q;

endmodule

// File: doc/snn_timestep_sequencer.md
Name: snn_timestep_sequencer

Overview:
Run controller for the two-layer delay SNN (M1=16 inputs, N1=8 hidden, N2=2 outputs). It accepts one input spike vector per timestep from a valid/ready source and drives the network's enable and delay_clk. It samples the output spikes each step and accumulates per-output spike counts over a programmable number of timesteps. At the end of the run it reports the counts, the layer-1 activity total and the winning output neuron.

Parameters:
M1, 16, input spike vector width
N1, 8, layer-1 neuron count
N2, 2, output neuron count
CNT_W, 8, per-output spike counter width (saturating)
ACT_W, 12, layer-1 activity counter width (saturating)
EVAL_CYCLES, 1, cycles net_enable is held high per step (>=1)
SETTLE_CYCLES, 2, idle cycles between the delay_clk pulse and the output sample (>=0)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin a run; sampled only in IDLE
abort  in  1  terminate the run; return to IDLE
num_steps  in  8  timesteps per run; latched at start
in_valid  in  1  input spike vector valid
in_spikes  in  M1  input spike vector
in_ready  out  1  sequencer accepts in_spikes
net_enable  out  1  drives network enable
net_delay_clk  out  1  drives network delay_clk; one-cycle pulse per step
net_input_spikes  out  M1  registered spike vector presented to the network
net_spikes_l1  in  N1  network layer-1 spikes
net_spikes_out  in  N2  network output spikes
busy  out  1  run in progress
done  out  1  one-cycle pulse; results valid from this cycle on
spike_counts  out  N2*CNT_W  packed counts; neuron k occupies [k*CNT_W +: CNT_W]
l1_activity  out  ACT_W  total layer-1 spikes sampled in the run
winner  out  max(1,clog2(N2))  index of the output with the maximum count
step_idx  out  8  number of completed steps in the current run

Behaviour:
- Reset (async): state IDLE. All outputs are 0, including net_input_spikes, counts, winner and step_idx.
- All outputs are registered, so they are Moore functions of the state.
- States: IDLE, WAIT_IN, EVAL, DCLK, SETTLE, SAMPLE, DONE.
- IDLE: busy=0.
  - start with num_steps!=0: clear counts, l1_activity, step_idx, winner and net_input_spikes; latch num_steps; go to WAIT_IN.
  - start with num_steps==0: go to DONE directly with all results 0.
- WAIT_IN: in_ready=1, busy=1. On the in_valid&&in_ready edge, latch in_spikes into net_input_spikes and go to EVAL. With in_valid low, the state holds and net_enable stays 0.
- EVAL: net_enable=1 for exactly EVAL_CYCLES cycles, then go to DCLK.
- DCLK: net_delay_clk=1 for one cycle. Go to SETTLE, or to SAMPLE if SETTLE_CYCLES=0.
- SETTLE: counts down SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE:
  - spike_counts[k] += net_spikes_out[k], saturating at 2^CNT_W-1.
  - l1_activity += popcount(net_spikes_l1), saturating at 2^ACT_W-1.
  - step_idx += 1.
  - If the new step_idx equals the latched num_steps, go to DONE; otherwise go to WAIT_IN.
- DONE: done=1 for one cycle. winner = lowest index holding the maximum count (ties go to the lower index). Then go to IDLE.
- Results and net_input_spikes hold until the next start.
- With default parameters, one step takes 6 cycles when in_valid is held high: WAIT_IN, EVAL, DCLK, SETTLE x2, SAMPLE.
- abort in any non-IDLE state: IDLE on the next edge. net_enable, net_delay_clk, in_ready and busy deassert; no done pulse; counts are frozen at their partial values. abort has priority over every transition, including the handshake.
- start while busy is ignored. start and abort asserted together in IDLE: abort wins and the state stays IDLE.
- in_spikes is never accepted outside WAIT_IN.

Decomposition:
- Package snn_seq_pkg: state enum (7 states, 3-bit encoding), default parameter constants, and a popcount function.
- One sub-module: snn_sat_accumulator. It is a parameterised saturating adder register with inputs clr, add_en and an increment value. It is instantiated N2 times for spike_counts (increment = 1 bit) and once for l1_activity (increment = popcount).

Test Plan:
- Reset mid-run (in EVAL) -> every output is 0 in the same cycle reset asserts; IDLE after release; no done.
- num_steps=3, in_valid held high, net_spikes_out=2'b01 and net_spikes_l1=8'h0F at each SAMPLE -> done on the 19th cycle after the start edge; spike_counts={0,3}; l1_activity=12; winner=0; step_idx=3; exactly 3 net_delay_clk pulses.
- Backpressure: in_valid low for 5 cycles in WAIT_IN -> in_ready stays 1, net_enable stays 0 and step_idx is unchanged; the step proceeds on the in_valid edge with net_input_spikes equal to the presented vector.
- Tie and winner: 4 steps with output patterns 10,01,10,01 -> counts {2,2}, winner=0. 4 steps of 2'b10 -> counts {4,0}, winner=1.
- Saturation (CNT_W=4): num_steps=20, net_spikes_out=2'b11 every step -> both counts=15, no wrap.
- Abort during DCLK of step 2 -> IDLE next cycle, busy=0, no done, step_idx=1. A following start with num_steps=0 -> done one cycle later with all results 0.
